// File: rtl/iccm_boot_mem.sv
// ----------------------------------------------------------------------------
// iccm_boot_mem
//
// Instruction memory with a streaming loader port and a registered fetch port.
// A boot FSM holds the core off (no fetch grants) until a program image has
// been streamed in and the loader signals completion. Fetches beyond the
// loaded image return an error response with zero data.
//
// Ports:
//   clock, reset      system clock; asynchronous active-high reset
//   ld_start          open (or restart) a load session, write pointer -> 0
//   ld_valid/ld_ready loader beat handshake
//   ld_data/ld_strb   loader word and per-byte write enables
//   ld_done           close the load session and release the core
//   load_count        words written in the current/last session
//   run               core released, fetches are granted
//   fetch_req/gnt     fetch request and combinational grant
//   fetch_addr        fetch word address
//   fetch_rvalid      response valid, one cycle after grant
//   fetch_rdata       fetched word (holds when no response)
//   fetch_err         response is outside the loaded image
// ----------------------------------------------------------------------------
module iccm_boot_mem #(
    parameter  int DataWidth = 32,
    parameter  int AddrWidth = 10,
    localparam int StrbWidth = DataWidth / 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ld_start,
    input  logic                 ld_valid,
    input  logic [DataWidth-1:0] ld_data,
    input  logic [StrbWidth-1:0] ld_strb,
    input  logic                 ld_done,
    output logic                 ld_ready,
    output logic [AddrWidth:0]   load_count,
    output logic                 run,
    input  logic                 fetch_req,
    input  logic [AddrWidth-1:0] fetch_addr,
    output logic                 fetch_gnt,
    output logic                 fetch_rvalid,
    output logic [DataWidth-1:0] fetch_rdata,
    output logic                 fetch_err
);

    localparam int unsigned      Depth    = 2 ** AddrWidth;
    localparam logic [AddrWidth:0] DepthCnt = (AddrWidth + 1)'(Depth);

    typedef enum logic [1:0] {
        StBoot,
        StLoad,
        StRun
    } state_e;

    state_e               state_q, state_d;
    logic [AddrWidth:0]   load_count_q, load_count_d;
    logic                 run_q;
    logic                 rvalid_q;
    logic [DataWidth-1:0] rdata_q;
    logic                 err_q;

    logic [DataWidth-1:0] mem_q [Depth];

    logic                 wr_en;
    logic [AddrWidth-1:0] wr_idx;
    logic                 fetch_oob;

    assign ld_ready  = (state_q == StLoad) && (load_count_q < DepthCnt);
    // A beat coinciding with ld_start belongs to no session and is dropped.
    assign wr_en     = ld_valid && ld_ready && !ld_start;
    assign wr_idx    = load_count_q[AddrWidth-1:0];
    assign fetch_gnt = run_q && fetch_req;
    assign fetch_oob = {1'b0, fetch_addr} >= load_count_q;

    always_comb begin
        state_d      = state_q;
        load_count_d = load_count_q;
        if (ld_start) begin
            // Start takes priority over done and over any beat.
            state_d      = StLoad;
            load_count_d = '0;
        end else begin
            unique case (state_q)
                StBoot: ;
                StLoad: begin
                    if (wr_en) begin
                        load_count_d = load_count_q + (AddrWidth + 1)'(1);
                    end
                    if (ld_done) begin
                        state_d = StRun;
                    end
                end
                StRun: ;
                default: state_d = StBoot;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StBoot;
            load_count_q <= '0;
            run_q        <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_count_q <= load_count_d;
            run_q        <= (state_d == StRun);
            rvalid_q     <= fetch_gnt;
            // Bounds are judged against the pre-edge count, so a grant on the
            // ld_start cycle still sees the previous image.
            if (fetch_gnt) begin
                err_q   <= fetch_oob;
                rdata_q <= fetch_oob ? '0 : mem_q[fetch_addr];
            end
        end
    end

    // Array is deliberately not reset: contents survive a reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < StrbWidth; b++) begin
                if (ld_strb[b]) begin
                    mem_q[wr_idx][b*8 +: 8] <= ld_data[b*8 +: 8];
                end
            end
        end
    end

    assign load_count   = load_count_q;
    assign run          = run_q;
    assign fetch_rvalid = rvalid_q;
    assign fetch_rdata  = rdata_q;
    assign fetch_err    = err_q;

endmodule

// File: tb/tb_iccm_boot_mem.sv
// ----------------------------------------------------------------------------
// tb_iccm_boot_mem
//
// Directed scenarios followed by randomized traffic, checked cycle by cycle
// against a behavioural model (mode, word count, memory image with a per-byte
// known mask so never-written bytes are not compared).
// ----------------------------------------------------------------------------
module tb_iccm_boot_mem;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    logic          clock = 1'b0;
    logic          reset;
    logic          ld_start, ld_valid, ld_done;
    logic [DW-1:0] ld_data;
    logic [SW-1:0] ld_strb;
    logic          ld_ready;
    logic [AW:0]   load_count;
    logic          run;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_gnt, fetch_rvalid, fetch_err;
    logic [DW-1:0] fetch_rdata;

    int checks   = 0;
    int failures = 0;

    iccm_boot_mem #(
        .DataWidth(DW),
        .AddrWidth(AW)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .ld_start    (ld_start),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_strb     (ld_strb),
        .ld_done     (ld_done),
        .ld_ready    (ld_ready),
        .load_count  (load_count),
        .run         (run),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_gnt   (fetch_gnt),
        .fetch_rvalid(fetch_rvalid),
        .fetch_rdata (fetch_rdata),
        .fetch_err   (fetch_err)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    typedef enum int {M_BOOT, M_LOAD, M_RUN} mode_t;
    mode_t         m_mode;
    int            m_cnt;
    logic [DW-1:0] m_mem   [DEPTH];
    logic [DW-1:0] m_known [DEPTH];
    bit            m_rvalid;
    bit            m_err;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] m_rmask;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]   = '0;
            m_known[i] = '0;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = M_BOOT;
        m_cnt    = 0;
        m_rvalid = 0;
        m_err    = 0;
        m_rdata  = '0;
        m_rmask  = '1;
    endtask

    task automatic idle();
        ld_start   = 0;
        ld_valid   = 0;
        ld_done    = 0;
        ld_data    = '0;
        ld_strb    = '0;
        fetch_req  = 0;
        fetch_addr = '0;
    endtask

    task automatic check_regs();
        check_eq("run", run, (m_mode == M_RUN));
        check_eq("load_count", load_count, m_cnt);
        check_eq("fetch_rvalid", fetch_rvalid, m_rvalid);
        if (m_rvalid) check_eq("fetch_err", fetch_err, m_err);
        if (m_rmask != '0) check_eq("fetch_rdata", fetch_rdata & m_rmask, m_rdata & m_rmask);
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        bit exp_ready, exp_gnt, beat;
        #1;
        exp_ready = (m_mode == M_LOAD) && (m_cnt < DEPTH);
        exp_gnt   = (m_mode == M_RUN) && fetch_req;
        check_eq("ld_ready", ld_ready, exp_ready);
        check_eq("fetch_gnt", fetch_gnt, exp_gnt);
        beat = ld_valid && exp_ready && !ld_start;
        @(posedge clock);
        m_rvalid = exp_gnt;
        if (exp_gnt) begin
            m_err = (fetch_addr >= m_cnt);
            if (m_err) begin
                m_rdata = '0;
                m_rmask = '1;
            end else begin
                m_rdata = m_mem[fetch_addr];
                m_rmask = m_known[fetch_addr];
            end
        end
        if (beat) begin
            for (int b = 0; b < SW; b++) begin
                if (ld_strb[b]) begin
                    m_mem[m_cnt][b*8 +: 8]   = ld_data[b*8 +: 8];
                    m_known[m_cnt][b*8 +: 8] = 8'hFF;
                end
            end
            m_cnt++;
        end
        if (ld_start) begin
            m_mode = M_LOAD;
            m_cnt  = 0;
        end else if (m_mode == M_LOAD && ld_done) begin
            m_mode = M_RUN;
        end
        #1;
        check_regs();
        @(negedge clock);
    endtask

    // Asynchronous assertion mid-cycle, release on a falling edge.
    task automatic do_reset();
        reset = 1;
        #1;
        model_reset();
        check_eq("rst_ld_ready", ld_ready, 0);
        check_eq("rst_fetch_gnt", fetch_gnt, 0);
        check_regs();
        @(negedge clock);
        reset = 0;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic [SW-1:0] s);
        ld_valid = 1;
        ld_data  = d;
        ld_strb  = s;
        step();
        ld_valid = 0;
    endtask

    task automatic pulse_start();
        ld_start = 1;
        step();
        ld_start = 0;
    endtask

    task automatic pulse_done();
        ld_done = 1;
        step();
        ld_done = 0;
    endtask

    task automatic fetch(input int a);
        fetch_req  = 1;
        fetch_addr = AW'(a);
        step();
        fetch_req  = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        model_reset();
        #2;
        check_regs();
        @(negedge clock);
        @(negedge clock);
        reset = 0;

        // Fetches are blocked before any load.
        fetch_req  = 1;
        fetch_addr = '0;
        repeat (5) step();
        fetch_req = 0;

        // First program, then back-to-back fetches including one past the image.
        pulse_start();
        beat(32'h00500293, 4'hF);
        beat(32'h00502A23, 4'hF);
        beat(32'h005282B3, 4'hF);
        beat(32'h01402283, 4'hF);
        pulse_done();
        fetch_req = 1;
        for (int a = 0; a <= 4; a++) begin
            fetch_addr = AW'(a);
            step();
        end
        fetch_req = 0;
        step();

        // Grant on the reload cycle still returns old data.
        ld_start   = 1;
        fetch_req  = 1;
        fetch_addr = AW'(2);
        step();
        check_eq("reload_word2", fetch_rdata, 32'h005282B3);
        ld_start  = 0;
        fetch_req = 1;
        step();
        fetch_req = 0;

        // Partial-strobe overwrite of word 0 in the new session.
        beat(32'hAABBCCDD, 4'b0101);
        pulse_done();
        fetch(0);
        check_eq("merge_word0", fetch_rdata, 32'h00BB02DD);
        fetch(1);

        // Overflow: more beats than words.
        pulse_start();
        for (int i = 0; i < DEPTH + 2; i++) beat($urandom, 4'hF);
        pulse_done();
        fetch_req = 1;
        for (int a = 0; a < DEPTH; a++) begin
            fetch_addr = AW'(a);
            step();
        end
        fetch_req = 0;

        // Reset mid-session; contents survive.
        pulse_start();
        beat(32'h11111111, 4'hF);
        beat(32'h22222222, 4'hF);
        do_reset();
        pulse_start();
        beat(32'h33333333, 4'hF);
        pulse_done();
        fetch(1);
        pulse_start();
        beat(32'h44444444, 4'hF);
        beat(32'h55555555, 4'h0);
        pulse_done();
        fetch(1);
        check_eq("retained_word1", fetch_rdata, 32'h22222222);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            ld_start   = ($urandom % 25 == 0);
            ld_done    = ($urandom % 10 == 0);
            ld_valid   = ($urandom % 2 == 0);
            ld_data    = $urandom;
            ld_strb    = SW'($urandom);
            fetch_req  = ($urandom % 3 != 0);
            fetch_addr = AW'($urandom);
            if ($urandom % 97 == 0) do_reset();
            else step();
        end
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
